// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives instruction memory and fills IF/ID.
// Optional out-of-range fetch trap: define FETCH_BOUNDS_CHECK_EN.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   stall         hold PC and IF/ID
//   redirect      load redirect_pc (wins over stall), inject bubble
//   redirect_pc   target byte address, bits [1:0] ignored
//   imem_pc       word address to instruction memory (pc_q[31:2])
//   imem_inst     instruction word for imem_pc
//   if_id_inst    registered instruction to decode
//   if_id_pc4     registered PC+4 of that instruction
//   if_id_valid   IF/ID holds a real instruction
//   fetch_count   instructions loaded valid into IF/ID
//   fetch_fault   sticky out-of-range fetch flag

package fetch_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        inst:  32'h0,
        pc4:   32'h0,
        valid: 1'b0
    };

endpackage

module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] IMEM_BASE  = 32'h0040_0000,
    parameter logic [31:0] IMEM_LIMIT = 32'h0040_0400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [29:0] imem_pc,
    input  logic [31:0] imem_inst,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic        fetch_fault
);

    logic [31:0] pc_q;
    if_id_t      if_id_q;
    logic [31:0] count_q;
    logic        fault_q;

    logic [31:0] pc_plus4;
    logic        oob;
    logic        unused_bits;

    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_BOUNDS_CHECK_EN
    assign oob = (pc_q < IMEM_BASE) ||
                 (pc_q >= IMEM_LIMIT);
    assign unused_bits = ^redirect_pc[1:0];
`else
    // No range check: the bounds only exist to keep
    // the parameter list identical across builds.
    assign oob = 1'b0;
    assign unused_bits = ^{redirect_pc[1:0],
                           IMEM_BASE, IMEM_LIMIT};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            if_id_q <= IF_ID_BUBBLE;
            count_q <= 32'h0;
            fault_q <= 1'b0;
        end else if (redirect) begin
            pc_q    <= {redirect_pc[31:2], 2'b00};
            if_id_q <= IF_ID_BUBBLE;
        end else if (fault_q) begin
            // Trapped: only a redirect can move the PC.
            if_id_q <= IF_ID_BUBBLE;
        end else if (stall) begin
            pc_q    <= pc_q;
        end else if (oob) begin
            if_id_q <= IF_ID_BUBBLE;
            fault_q <= 1'b1;
        end else begin
            pc_q          <= pc_plus4;
            if_id_q.inst  <= imem_inst;
            if_id_q.pc4   <= pc_plus4;
            if_id_q.valid <= 1'b1;
            count_q       <= count_q + 32'd1;
        end
    end

    assign imem_pc     = pc_q[31:2];
    assign if_id_inst  = if_id_q.inst;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_valid = if_id_q.valid;
    assign fetch_count = count_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random stimulus against a
// cycle-level reference model of the fetch stage.

module tb_fetch_stage;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam logic [31:0] LIMIT = 32'h0040_0400;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [29:0] imem_pc;
    logic [31:0] imem_inst;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_count;
    logic        m_fault;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_pc     (imem_pc),
        .imem_inst   (imem_inst),
        .if_id_inst  (if_id_inst),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .fetch_count (fetch_count),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [29:0] wa);
        logic [29:0] off;
        off = wa - 30'h0010_0000;
        if (off < 30'd256)
            return mem[off[7:0]];
        return {2'b00, wa} ^ 32'hA5A5_0000;
    endfunction

    always_comb imem_inst = word_at(imem_pc);

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit r, input bit s,
                              input bit d, input logic [31:0] t);
        bit out_of_range;
        out_of_range = (m_pc < BASE) || (m_pc >= LIMIT);
        if (!r) begin
            m_pc = BASE; m_inst = 0; m_pc4 = 0;
            m_valid = 0; m_count = 0; m_fault = 0;
        end else if (d) begin
            m_pc = {t[31:2], 2'b00};
            m_inst = 0; m_pc4 = 0; m_valid = 0;
        end else if (BC && m_fault) begin
            m_inst = 0; m_pc4 = 0; m_valid = 0;
        end else if (s) begin
            // everything holds
        end else if (BC && out_of_range) begin
            m_inst = 0; m_pc4 = 0; m_valid = 0;
            m_fault = 1;
        end else begin
            m_inst  = word_at(m_pc[31:2]);
            m_pc4   = m_pc + 4;
            m_valid = 1;
            m_count = m_count + 1;
            m_pc    = m_pc + 4;
        end
    endtask

    task automatic check_all();
        check("imem_pc", {2'b00, imem_pc}, {2'b00, m_pc[31:2]});
        check("if_id_inst", if_id_inst, m_inst);
        check("if_id_pc4", if_id_pc4, m_pc4);
        check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        check("fetch_count", fetch_count, m_count);
        check("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
    endtask

    task automatic step(input bit r, input bit s,
                        input bit d, input logic [31:0] t);
        rst_n = r; stall = s; redirect = d; redirect_pc = t;
        model_edge(r, s, d, t);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = $urandom;
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'h0000_000C;
        mem[5] = 32'h0000_0000;
        m_pc = 'x; m_inst = 'x; m_pc4 = 'x;
        m_valid = 'x; m_count = 'x; m_fault = 'x;

        // reset
        step(0, 0, 0, 0);
        step(0, 1, 1, 32'h1234_5678);
        check("reset imem_pc", {2'b00, imem_pc}, 32'h0010_0000);

        // two fetches, 3-cycle stall, then resume
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("inst2", if_id_inst, 32'h2009_0002);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            check("stall pc", {2'b00, imem_pc}, 32'h0010_0002);
            check("stall cnt", fetch_count, 32'd2);
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("pc4 #4", if_id_pc4, 32'h0040_0010);
        check("count 4", fetch_count, 32'd4);

        // nop (word 0) still counts
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("nop valid", {31'h0, if_id_valid}, 32'h1);

        // redirect with stall; penalty is one bubble
        step(1, 1, 1, 32'h0040_0023);
        check("redir pc", {2'b00, imem_pc}, 32'h0010_0008);
        step(1, 0, 0, 0);
        check("redir inst", if_id_inst, mem[8]);

        // back-to-back redirects: only the last is fetched
        step(1, 0, 1, 32'h0040_0040);
        step(1, 0, 1, 32'h0040_0080);
        step(1, 0, 0, 0);
        check("redir2 inst", if_id_inst, mem[32]);

        // count wrap via preload during a stall
        stall = 1;
        redirect = 0;
        rst_n = 1;
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        m_count = 32'hFFFF_FFFF;
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        check("wrap", fetch_count, 32'h0);

        // out-of-range fetch, then recovery
        step(1, 0, 1, 32'h0040_0400);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0040_0000);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("resume inst", if_id_inst, mem[1]);

        // reset mid-stall with valid IF/ID
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        check("rst valid", {31'h0, if_id_valid}, 32'h0);
        check("rst count", fetch_count, 32'h0);
        step(1, 0, 0, 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            bit r, s, d;
            logic [31:0] t;
            r = ($urandom_range(0, 99) >= 2);
            s = ($urandom_range(0, 99) < 25);
            d = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) < 5)
                t = $urandom;
            else
                t = BASE + ($urandom_range(0, 255) << 2)
                    + $urandom_range(0, 3);
            step(r, s, d, t);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
